binary16_sum_sq: RTL and testbench
==================================

Name: binary16_sum_sq

Overview:
- Upstream feeder for binary16_sqrt in the vector-magnitude path.
- Accepts a stream of binary16 vector components and accumulates the sum of their squares.
- Emits one non-negative binary16 result per vector, framed by last_in, so the downstream sqrt never sees a negative operand.
- Multi-cycle, non-pipelined FSM with a ready/valid input handshake.

Parameters:
- MAX_LEN, 16: maximum components per vector. Reaching it without last_in forces the vector closed.
- GUARD_BITS, 3: extra mantissa bits kept in the internal accumulator below the 11-bit significand.

Ports:
- clk_in  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  16  binary16 component.
- data_valid_in  input  1  component present on data_in.
- last_in  input  1  final component of the current vector; qualified by data_valid_in.
- ready_out  output  1  block can accept a component this cycle.
- result  output  16  binary16 sum of squares; bit 15 is always 0.
- data_valid_out  output  1  one-cycle strobe; result is valid.
- sat_out  output  1  valid with data_valid_out; the result saturated or the vector was force-closed.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst is synchronous and active-high.
- Reset values: ready_out=1, data_valid_out=0, result=0, sat_out=0, busy=0, state=IDLE, accumulator=0, element count=0, sticky sat=0.
- Reset mid-operation discards the partial vector with no output strobe. rst has priority over all other inputs.

States:
- IDLE: ready_out=1. An accept occurs when data_valid_in=1 in IDLE. On accept, register data_in and last_in, increment the count, and go to MUL. With no accept, stay in IDLE.
- MUL: square the significand, 11x11 to 22 bits; biased exponent = 2e-15+(M²≥2). Then go to ALIGN.
- ALIGN: right-shift the smaller operand of {square, accumulator} by the exponent difference. Shifted-out bits are truncated, with no sticky bit. Then go to ADD.
- ADD: unsigned significand add. Both operands are non-negative, so there is no subtraction. Then go to NORM.
- NORM: renormalise at most one bit right and truncate to 11+GUARD_BITS bits. Then go to DONE if the registered last flag is set or count==MAX_LEN; otherwise go to IDLE.
- DONE: pack the accumulator to binary16 by truncation, drive result, pulse data_valid_out and sat_out, clear the accumulator, count and sticky sat, then go to IDLE.
- Timing: for a component accepted at edge k, data_valid_out is high for exactly the cycle following edge k+5. Throughput is one component per 5 cycles. Inputs are ignored whenever ready_out=0.

Input classes:
- Sign is ignored, since squares are positive.
- Exponent field 0 (zero or subnormal) contributes 0.
- Exponent field 31 (Inf or NaN) sets sticky sat.
- Underflow: a square with biased exponent ≤0 flushes to 0 and does not set sat.

Accumulator and packing:
- Internal exponent is 6 bits, so values above binary16 range are held until DONE.
- At pack, exponent ≥31 or sticky sat set gives result=0x7BFF and sat_out=1.
- An accumulator of 0 packs to 0x0000.

Forced close:
- count==MAX_LEN without last_in closes the vector and sets sat_out=1. The output is the accumulated value.
- A following last_in starts a new vector.

Optional Feature:
- Macro: BINARY16_SUM_SQ_ROUND_NEAREST_EN.
- Defined: the pack step in DONE rounds to nearest-even using the guard bits. A mantissa carry increments the exponent. If rounding reaches exponent 31, saturate to 0x7BFF with sat_out=1.
- Undefined: truncation toward zero, as above.
- Latency is identical in both builds.

Test Plan:
- 0x4200 (3.0) then 0x4400 (4.0) with last_in -> result 0x4E40 (25.0), sat_out=0. data_valid_out rises 5 edges after the second accept.
- Single 0xC000 (-2.0) with last_in -> 0x4400 (4.0); single 0x0000 with last_in -> 0x0000.
- Single 0x5C00 (256.0) with last_in -> 0x7BFF, sat_out=1. Also 0x7C00 (Inf) with last_in -> 0x7BFF, sat_out=1.
- 16 × 0x3C00 (1.0) with no last_in, MAX_LEN=16 -> after the 16th component, 0x4C00 (16.0) with sat_out=1. A following 0x3C00 with last_in -> 0x3C00.
- Hold data_valid_in high continuously -> components are sampled only in IDLE cycles (ready_out=1), one per 5 cycles.
- Assert rst during ALIGN of a 2-component vector -> no data_valid_out; ready_out=1 the cycle after reset. A new 0x3C00 with last_in -> 0x3C00.

Source files
------------

// File: rtl/binary16_sum_sq_if.sv
// Component stream and result bus between the vector-magnitude front end
// and the binary16 sum-of-squares accumulator.
interface binary16_sum_sq_if;
    logic [15:0] data_in;
    logic        data_valid_in;
    logic        last_in;
    logic        ready_out;
    logic [15:0] result;
    logic        data_valid_out;
    logic        sat_out;
    logic        busy;

    modport master (
        output data_in, data_valid_in, last_in,
        input  ready_out, result, data_valid_out, sat_out, busy
    );

    modport slave (
        input  data_in, data_valid_in, last_in,
        output ready_out, result, data_valid_out, sat_out, busy
    );
endinterface

// File: rtl/binary16_sum_sq.sv
// Accumulates the sum of squares of a stream of binary16 components and
// emits one non-negative binary16 result per vector (framed by last_in or
// by reaching MAX_LEN components). Non-pipelined: one component per 5 cycles.
// Optional build macro BINARY16_SUM_SQ_ROUND_NEAREST_EN selects
// round-to-nearest-even at pack time instead of truncation.
module binary16_sum_sq #(
    parameter int unsigned MAX_LEN    = 16,
    parameter int unsigned GUARD_BITS = 3
) (
    input  logic clk_in,
    input  logic rst,
    binary16_sum_sq_if.slave bus
);
    localparam int unsigned SW = 11 + GUARD_BITS;      // internal significand width
    localparam int unsigned CW = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {IDLE, MUL, ALIGN, ADD, NORM, DONE} state_t;

    state_t        state;
    logic [14:0]   din_r;       // sign bit dropped: squares are positive
    logic          last_r;
    logic [CW-1:0] count;
    logic          sticky_sat;
    logic [SW-1:0] sq_sig, acc_sig, al_big, al_small;
    logic [5:0]    sq_exp, acc_exp, al_exp;
    logic [SW:0]   sum_r;
    logic          ready_r, valid_r, sat_r, busy_r;
    logic [15:0]   result_r;

    // MUL: square the significand, normalise, flush underflow to zero
    logic [10:0]   m;
    logic [SW:0]   p_top;
    logic [7:0]    t;
    logic [SW-1:0] sq_sig_c;
    logic [5:0]    sq_exp_c;
    logic          sq_zero_c, sq_inf_c;
    always_comb begin
        m         = {1'b1, din_r[9:0]};
        p_top     = (SW+1)'(({11'b0, m} * {11'b0, m}) >> (21 - SW));
        t         = {2'b00, din_r[14:10], 1'b0} + {7'b0, p_top[SW]};
        sq_sig_c  = p_top[SW] ? p_top[SW:1] : p_top[SW-1:0];
        sq_exp_c  = 6'(t - 8'd15);
        sq_inf_c  = (din_r[14:10] == 5'd31);
        sq_zero_c = (din_r[14:10] == 5'd0) || sq_inf_c || (t <= 8'd15);
    end

    // ALIGN: shift the smaller operand right to the larger exponent (truncating)
    logic [SW-1:0] big_c, small_c;
    logic [5:0]    bexp_c;
    always_comb begin
        big_c   = acc_sig;
        small_c = '0;
        bexp_c  = acc_exp;
        if (sq_sig == '0) begin
            big_c  = acc_sig;
            bexp_c = acc_exp;
        end else if (acc_sig == '0) begin
            big_c  = sq_sig;
            bexp_c = sq_exp;
        end else if (sq_exp >= acc_exp) begin
            big_c   = sq_sig;
            small_c = acc_sig >> (sq_exp - acc_exp);
            bexp_c  = sq_exp;
        end else begin
            big_c   = acc_sig;
            small_c = sq_sig >> (acc_exp - sq_exp);
            bexp_c  = acc_exp;
        end
    end

    // DONE: pack accumulator to binary16 and decide saturation
    logic [9:0]  mant_c;
    logic [6:0]  exp_p;
    logic        ovf_c, forced_c, pk_sat;
    logic [15:0] pk_res;
`ifdef BINARY16_SUM_SQ_ROUND_NEAREST_EN
    localparam logic [GUARD_BITS-1:0] HALF = GUARD_BITS'(1) << (GUARD_BITS - 1);
    logic [GUARD_BITS-1:0] grd;
    logic                  rnd_up;
    logic [10:0]           mant_r;
`endif
    always_comb begin
`ifdef BINARY16_SUM_SQ_ROUND_NEAREST_EN
        grd    = acc_sig[GUARD_BITS-1:0];
        rnd_up = (grd > HALF) || ((grd == HALF) && acc_sig[GUARD_BITS]);
        mant_r = {1'b0, acc_sig[SW-2:GUARD_BITS]} + {10'b0, rnd_up};
        // mantissa carry: 1.11..1 rounds up to 10.0, i.e. mantissa 0 at exp+1
        mant_c = mant_r[10] ? 10'd0 : mant_r[9:0];
        exp_p  = {1'b0, acc_exp} + {6'b0, mant_r[10]};
`else
        mant_c = acc_sig[SW-2:GUARD_BITS];
        exp_p  = {1'b0, acc_exp};
`endif
        ovf_c    = sticky_sat || (exp_p >= 7'd31);
        forced_c = (count == CW'(MAX_LEN)) && !last_r;
        pk_sat   = ovf_c || forced_c;
        if (ovf_c)
            pk_res = 16'h7BFF;
        else if (acc_sig == '0)
            pk_res = 16'h0000;
        else
            pk_res = {1'b0, exp_p[4:0], mant_c};
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state      <= IDLE;
            din_r      <= '0;
            last_r     <= 1'b0;
            count      <= '0;
            sticky_sat <= 1'b0;
            sq_sig     <= '0;
            sq_exp     <= '0;
            acc_sig    <= '0;
            acc_exp    <= '0;
            al_big     <= '0;
            al_small   <= '0;
            al_exp     <= '0;
            sum_r      <= '0;
            ready_r    <= 1'b1;
            valid_r    <= 1'b0;
            sat_r      <= 1'b0;
            busy_r     <= 1'b0;
            result_r   <= '0;
        end else begin
            valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.data_valid_in) begin
                        din_r   <= bus.data_in[14:0];
                        last_r  <= bus.last_in;
                        count   <= count + CW'(1);
                        state   <= MUL;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                    end
                end
                MUL: begin
                    sq_sig <= sq_zero_c ? '0 : sq_sig_c;
                    sq_exp <= sq_zero_c ? '0 : sq_exp_c;
                    if (sq_inf_c)
                        sticky_sat <= 1'b1;
                    state <= ALIGN;
                end
                ALIGN: begin
                    al_big   <= big_c;
                    al_small <= small_c;
                    al_exp   <= bexp_c;
                    state    <= ADD;
                end
                ADD: begin
                    sum_r <= {1'b0, al_big} + {1'b0, al_small};
                    state <= NORM;
                end
                NORM: begin
                    if (sum_r[SW]) begin
                        acc_sig <= sum_r[SW:1];
                        acc_exp <= al_exp + 6'd1;
                    end else begin
                        acc_sig <= sum_r[SW-1:0];
                        acc_exp <= (sum_r == '0) ? 6'd0 : al_exp;
                    end
                    if (last_r || (count == CW'(MAX_LEN))) begin
                        state <= DONE;
                    end else begin
                        state   <= IDLE;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                DONE: begin
                    result_r   <= pk_res;
                    sat_r      <= pk_sat;
                    valid_r    <= 1'b1;
                    acc_sig    <= '0;
                    acc_exp    <= '0;
                    count      <= '0;
                    sticky_sat <= 1'b0;
                    state      <= IDLE;
                    ready_r    <= 1'b1;
                    busy_r     <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready_out      = ready_r;
    assign bus.result         = result_r;
    assign bus.data_valid_out = valid_r;
    assign bus.sat_out        = sat_r;
    assign bus.busy           = busy_r;
endmodule

// File: tb/tb_binary16_sum_sq.sv
// Scoreboard bench for binary16_sum_sq: directed vectors with hand-computed
// results; a monitor pops expectations on every output strobe.
module tb_binary16_sum_sq;
    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    int   cyc    = 0;
    int   compared   = 0;
    int   mismatched = 0;

    typedef struct {
        logic [15:0] res;
        logic        sat;
        int          at;
    } exp_t;
    exp_t sb[$];

    binary16_sum_sq_if bus();

    binary16_sum_sq #(.MAX_LEN(16), .GUARD_BITS(3)) dut (
        .clk_in(clk_in),
        .rst(rst),
        .bus(bus.slave)
    );

    initial forever #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Monitor: every strobe must match the oldest expectation, including its cycle
    always @(negedge clk_in) begin
        if (!rst && bus.data_valid_out) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_strobe: result=%h sat=%b cyc=%0d, required no strobe",
                         bus.result, bus.sat_out, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.result !== e.res || bus.sat_out !== e.sat || cyc != e.at) begin
                    mismatched++;
                    $display("FAIL result: got %h sat=%b cyc=%0d, required %h sat=%b cyc=%0d",
                             bus.result, bus.sat_out, cyc, e.res, e.sat, e.at);
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] req);
        compared++;
        if (got !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Drive one component; returns the edge number at which it was accepted
    task automatic send(input logic [15:0] d, input logic l, output int ac);
        int budget;
        budget = 0;
        @(negedge clk_in);
        bus.data_in       = d;
        bus.last_in       = l;
        bus.data_valid_in = 1'b1;
        while (!bus.ready_out && budget < 50) begin
            @(negedge clk_in);
            budget++;
        end
        if (!bus.ready_out) begin
            compared++;
            mismatched++;
            $display("FAIL ready_timeout: ready_out=0 after %0d cycles, required 1", budget);
        end
        ac = cyc + 1;
        @(posedge clk_in);
        #1;
        bus.data_valid_in = 1'b0;
        bus.last_in       = 1'b0;
    endtask

    task automatic expect_out(input logic [15:0] r, input logic s, input int ac);
        exp_t e;
        e.res = r;
        e.sat = s;
        e.at  = ac + 5;
        sb.push_back(e);
    endtask

    initial begin
        int ac;
        int acc_at[4];
        int n;
        int budget;
        bus.data_in       = '0;
        bus.data_valid_in = 1'b0;
        bus.last_in       = 1'b0;
        repeat (3) @(negedge clk_in);
        rst = 1'b0;
        @(negedge clk_in);
        check("reset_ready", {15'b0, bus.ready_out}, 16'd1);
        check("reset_valid", {15'b0, bus.data_valid_out}, 16'd0);
        check("reset_result", bus.result, 16'h0000);
        check("reset_sat", {15'b0, bus.sat_out}, 16'd0);
        check("reset_busy", {15'b0, bus.busy}, 16'd0);

        // 3^2 + 4^2 = 25
        send(16'h4200, 1'b0, ac);
        send(16'h4400, 1'b1, ac); expect_out(16'h4E40, 1'b0, ac);
        // sign ignored, zero contributes zero
        send(16'hC000, 1'b1, ac); expect_out(16'h4400, 1'b0, ac);
        send(16'h0000, 1'b1, ac); expect_out(16'h0000, 1'b0, ac);
        // 256^2 overflows; Inf is sticky
        send(16'h5C00, 1'b1, ac); expect_out(16'h7BFF, 1'b1, ac);
        send(16'h7C00, 1'b1, ac); expect_out(16'h7BFF, 1'b1, ac);
        // 16 ones without last: forced close at 16.0 with sat
        for (int i = 0; i < 16; i++) send(16'h3C00, 1'b0, ac);
        expect_out(16'h4C00, 1'b1, ac);
        send(16'h3C00, 1'b1, ac); expect_out(16'h3C00, 1'b0, ac);
        // busy high while processing
        send(16'h3C00, 1'b1, ac); expect_out(16'h3C00, 1'b0, ac);
        @(negedge clk_in);
        check("busy_mid", {15'b0, bus.busy}, 16'd1);
        check("ready_mid", {15'b0, bus.ready_out}, 16'd0);

        // valid held high: accepts only when ready, one per 5 cycles
        @(negedge clk_in);
        while (!bus.ready_out) @(negedge clk_in);
        bus.data_in       = 16'h3C00;
        bus.last_in       = 1'b0;
        bus.data_valid_in = 1'b1;
        n = 0;
        budget = 0;
        while (n < 4 && budget < 60) begin
            if (bus.ready_out) begin
                acc_at[n] = cyc + 1;
                n++;
                if (n == 3) begin
                    @(posedge clk_in);
                    #1 bus.last_in = 1'b1;
                end else if (n == 4) begin
                    @(posedge clk_in);
                    #1 bus.data_valid_in = 1'b0;
                    bus.last_in = 1'b0;
                end
            end
            @(negedge clk_in);
            budget++;
        end
        check("held_accepts", 16'(n), 16'd4);
        if (n == 4) begin
            expect_out(16'h4400, 1'b0, acc_at[3]);
            for (int i = 1; i < 4; i++)
                check("held_gap", 16'(acc_at[i] - acc_at[i-1]), 16'd5);
        end

        // reset during ALIGN discards the vector
        send(16'h4200, 1'b0, ac);
        @(negedge clk_in);
        while (!bus.ready_out) @(negedge clk_in);
        bus.data_in       = 16'h4400;
        bus.last_in       = 1'b1;
        bus.data_valid_in = 1'b1;
        @(posedge clk_in);          // accepted, MUL next
        #1 bus.data_valid_in = 1'b0;
        bus.last_in = 1'b0;
        @(posedge clk_in);          // now in ALIGN
        @(negedge clk_in);
        rst = 1'b1;
        @(negedge clk_in);
        rst = 1'b0;
        check("rst_ready", {15'b0, bus.ready_out}, 16'd1);
        check("rst_busy", {15'b0, bus.busy}, 16'd0);
        repeat (8) @(negedge clk_in);
        send(16'h3C00, 1'b1, ac); expect_out(16'h3C00, 1'b0, ac);

        budget = 0;
        while (sb.size() != 0 && budget < 200) begin
            @(negedge clk_in);
            budget++;
        end
        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end
        repeat (10) @(negedge clk_in);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
